// File: rtl/data_mem_responder.sv
// data_mem_responder: RV32 data RAM + MMIO timer/status/scratch; ports clk, reset, mem_read, mem_write, address, wdata, fn3 -> mem_out, timer_irq, misalign_err
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic [2:0]  fn3,
    output logic [31:0] mem_out,
    output logic        timer_irq,
    output logic        misalign_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    logic [31:0] ram [0:DEPTH_WORDS-1];
    logic [31:0] mtime, mtimecmp, scratch;
    logic [1:0]  status;
    logic        sz_b, sz_h, sz_w, is_mmio, is_ram, reg_hit, mis, err, ram_we, reg_we, w1c;
    logic [31:0] ram_word, mmio_word, word, sh, ld, wd;
    logic [3:0]  be;
    logic [AW-1:0] idx;
    assign sz_b      = fn3 == 3'b000 || fn3 == 3'b100;
    assign sz_h      = fn3 == 3'b001 || fn3 == 3'b101;
    assign sz_w      = fn3 == 3'b010;
    assign is_mmio   = address[31:28] == MMIO_BASE[31:28];
    assign is_ram    = !is_mmio && address < 32'(DEPTH_WORDS) * 32'd4;
    assign reg_hit   = is_mmio && address[27:4] == 24'd0;
    assign mis       = is_mmio ? (!sz_w || address[1:0] != 2'd0)
                               : (sz_h && address[0]) || (sz_w && address[1:0] != 2'd0);
    assign err       = (mem_read || mem_write) && mis;
    assign idx       = address[AW+1:2];
    assign ram_word  = ram[idx];
    assign mmio_word = address[3:2] == 2'd0 ? mtime :
                       address[3:2] == 2'd1 ? mtimecmp :
                       address[3:2] == 2'd2 ? {30'd0, status} : scratch;
    assign word      = is_ram ? ram_word : reg_hit ? mmio_word : 32'd0;
    assign sh        = word >> {address[1:0], 3'b000};
    assign ld        = sz_w ? word :
                       sz_h ? {{16{sh[15] & ~fn3[2]}}, sh[15:0]} :
                       sz_b ? {{24{sh[7] & ~fn3[2]}}, sh[7:0]} : 32'd0;
    assign mem_out   = mem_read && !mis ? ld : 32'd0;
    assign ram_we    = mem_write && is_ram && !mis && (sz_b || sz_h || sz_w);
    assign be        = sz_w ? 4'hF : sz_h ? (address[1] ? 4'hC : 4'h3) : 4'b0001 << address[1:0];
    assign wd        = sz_w ? wdata : sz_h ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    assign reg_we    = mem_write && reg_hit && !mis;
    assign w1c       = reg_we && address[3:2] == 2'd2;
    assign timer_irq    = status[0];
    assign misalign_err = status[1];
    always_ff @(posedge clk) begin
        if (ram_we)
            for (int i = 0; i < 4; i++)
                if (be[i]) ram[idx][8*i +: 8] <= wd[8*i +: 8];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime    <= 32'd0;
            mtimecmp <= 32'hFFFF_FFFF;
            status   <= 2'd0;
            scratch  <= 32'd0;
        end else begin
            mtime     <= reg_we && address[3:2] == 2'd0 ? wdata : mtime + 32'd1;
            mtimecmp  <= reg_we && address[3:2] == 2'd1 ? wdata : mtimecmp;
            scratch   <= reg_we && address[3:2] == 2'd3 ? wdata : scratch;
            status[0] <= mtime == mtimecmp || (status[0] && !(w1c && wdata[0]));
            status[1] <= err || (status[1] && !(w1c && wdata[1]));
        end
    end
endmodule
